// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider channels.
package clk_div_pkg;

    localparam int DIV_MIN   = 2;
    localparam int DIV_W_PKG = 8;

    typedef logic [DIV_W_PKG-1:0] div_t;

    // RUN: enabled; DRAIN: disabled but finishing the period; IDLE: parked at cnt 0
    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_RUN   = 2'd1,
        CH_DRAIN = 2'd2
    } ch_state_e;

    function automatic logic [31:0] hi_len(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < 32'(DIV_MIN)) ? 32'(DIV_MIN) : v;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: period counter, pending-ratio register and
// a RUN/DRAIN/IDLE enable FSM so ratio changes and stops happen only at period boundaries.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    input  logic             ch_en,
    output logic             clk_out,
    output logic             tick,
    output logic             upd_pend,
    output ch_state_e        state
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(clamp_div(32'(DEFAULT_DIV)));

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] n_q, n_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             upd_pend_q, upd_pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    ch_state_e        state_q, state_d;

    logic             step;
    logic             last;
    logic [DIV_W-1:0] hi;

    // A period in progress always completes; a new one starts only when enabled.
    assign step = ch_en || (cnt_q != '0);
    assign last = (cnt_q == n_q - 1'b1);
    assign hi   = DIV_W'(hi_len(32'(n_q)));

    always_comb begin
        cnt_d      = cnt_q;
        n_d        = n_q;
        pend_div_d = pend_div_q;
        upd_pend_d = upd_pend_q;
        clk_out_d  = 1'b0;
        tick_d     = 1'b0;
        state_d    = state_q;

        if (step) begin
            clk_out_d = (cnt_q < hi);
            tick_d    = (cnt_q == '0);
            cnt_d     = last ? '0 : cnt_q + 1'b1;
        end

        // Apply uses the ratio pending before this edge, so a same-cycle load waits a period.
        if (upd_pend_q && (!step || last)) begin
            n_d        = pend_div_q;
            upd_pend_d = 1'b0;
            cnt_d      = '0;
        end

        if (div_load) begin
            pend_div_d = DIV_W'(clamp_div(32'(div_val)));
            upd_pend_d = 1'b1;
        end

        if (!step) begin
            state_d = CH_IDLE;
        end else if (ch_en) begin
            state_d = CH_RUN;
        end else if (cnt_d == '0) begin
            state_d = CH_IDLE;
        end else begin
            state_d = CH_DRAIN;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            n_q        <= RST_DIV;
            pend_div_q <= RST_DIV;
            upd_pend_q <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            state_q    <= CH_IDLE;
        end else begin
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            pend_div_q <= pend_div_d;
            upd_pend_q <= upd_pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            state_q    <= state_d;
        end
    end

    assign clk_out  = clk_out_q;
    assign tick     = tick_q;
    assign upd_pend = upd_pend_q;
    assign state    = state_q;

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider: NUM_CH independent clk_div_ch instances
// sharing clk_in; the top only slices the per-channel buses.
module prog_clk_div
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic [NUM_CH*DIV_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       upd_pend,
    output logic [NUM_CH*2-1:0]     dbg_state
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_state_e st;

        clk_div_ch #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk_in  (clk_in),
            .reset   (reset),
            .div_val (div_val[c*DIV_W +: DIV_W]),
            .div_load(div_load[c]),
            .ch_en   (ch_en[c]),
            .clk_out (clk_out[c]),
            .tick    (tick[c]),
            .upd_pend(upd_pend[c]),
            .state   (st)
        );

        assign dbg_state[2*c +: 2] = st;
    end

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: a period-pattern model checked every cycle, plus
// directed scenarios with hand-computed run lengths and reset behaviour.
module tb_prog_clk_div;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;
    localparam int DEF    = 2;
    localparam int GUARD  = 600;

    logic                    clk_in;
    logic                    reset;
    logic [NUM_CH*DIV_W-1:0] div_val;
    logic [NUM_CH-1:0]       div_load;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       upd_pend;
    logic [NUM_CH*2-1:0]     dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    prog_clk_div #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .div_val  (div_val),
        .div_load (div_load),
        .ch_en    (ch_en),
        .clk_out  (clk_out),
        .tick     (tick),
        .upd_pend (upd_pend),
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s ch%0d at %0t: got %0d expected %0d", name, c, $time, act, exp);
        end
    endtask

    // model: each period is a list of {tick,level} entries, H highs then N-H lows
    logic [1:0] mq [NUM_CH][$];
    int         m_n    [NUM_CH];
    int         m_pval [NUM_CH];
    bit         m_pend [NUM_CH];
    logic       m_out  [NUM_CH];
    logic       m_tick [NUM_CH];

    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mq[c].delete();
                m_n[c]    = DEF;
                m_pval[c] = DEF;
                m_pend[c] = 0;
                m_out[c]  = 0;
                m_tick[c] = 0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                bit         was_pend;
                logic [1:0] item;
                int         v;
                was_pend = m_pend[c];
                if (mq[c].size() != 0 || ch_en[c]) begin
                    if (mq[c].size() == 0)
                        for (int k = 0; k < m_n[c]; k++)
                            mq[c].push_back({k == 0, k < (m_n[c] + 1) / 2});
                    item      = mq[c].pop_front();
                    m_tick[c] = item[1];
                    m_out[c]  = item[0];
                    if (mq[c].size() == 0 && was_pend) begin
                        m_n[c]    = m_pval[c];
                        m_pend[c] = 0;
                    end
                end else begin
                    m_out[c]  = 0;
                    m_tick[c] = 0;
                    if (was_pend) begin
                        m_n[c]    = m_pval[c];
                        m_pend[c] = 0;
                    end
                end
                if (div_load[c]) begin
                    v         = int'(div_val[c*DIV_W +: DIV_W]);
                    m_pval[c] = (v < 2) ? 2 : v;
                    m_pend[c] = 1;
                end
            end
        end
    end

    // scoreboard compare every cycle
    always @(negedge clk_in) begin
        if (chk_on) begin
            for (int c = 0; c < NUM_CH; c++) begin
                chk("model_clk_out", c, 32'(clk_out[c]), 32'(m_out[c]));
                chk("model_tick", c, 32'(tick[c]), 32'(m_tick[c]));
                chk("model_upd_pend", c, 32'(upd_pend[c]), 32'(m_pend[c]));
            end
        end
    end

    // driver tasks
    task automatic cyc();
        @(negedge clk_in);
    endtask

    task automatic load(input int c, input int v);
        div_val[c*DIV_W +: DIV_W] = DIV_W'(v);
        div_load[c] = 1'b1;
        cyc();
        div_load[c] = 1'b0;
    endtask

    task automatic wait_pend_clear(input int c);
        int g;
        g = 0;
        while (upd_pend[c] && g < GUARD) begin
            cyc();
            g++;
        end
        if (g >= GUARD) chk("timeout_pend_clear", c, 32'(upd_pend[c]), 0);
    endtask

    task automatic wait_tick(input int c);
        int g;
        g = 0;
        while (!tick[c] && g < GUARD) begin
            cyc();
            g++;
        end
        if (g >= GUARD) chk("timeout_tick", c, 32'(tick[c]), 1);
    endtask

    // measures high and low run lengths of one full period, ending on the next tick sample
    task automatic run_lens(input int c, output int hi, output int lo);
        wait_tick(c);
        hi = 1;
        cyc();
        while (clk_out[c] && hi < GUARD) begin
            hi++;
            cyc();
        end
        lo = 0;
        while (!tick[c] && lo < GUARD) begin
            lo++;
            cyc();
        end
    endtask

    initial begin
        int hi, lo;
        logic [7:0] exp_seq;

        reset    = 1'b1;
        ch_en    = '0;
        div_load = '0;
        div_val  = '0;
        repeat (3) cyc();

        chk("reset_clk_out", 0, 32'(clk_out), 0);
        chk("reset_tick", 0, 32'(tick), 0);
        chk("reset_upd_pend", 0, 32'(upd_pend), 0);

        // 1: default ratio on both channels
        chk_on = 1;
        ch_en  = 2'b11;
        reset  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t1_clk_out", i, 32'(clk_out), (i % 2 == 0) ? 32'd3 : 32'd0);
            chk("t1_tick", i, 32'(tick), (i % 2 == 0) ? 32'd3 : 32'd0);
        end

        // 2: ratio 5 on ch0
        load(0, 5);
        chk("t2_upd_pend", 0, 32'(upd_pend[0]), 1);
        wait_pend_clear(0);
        run_lens(0, hi, lo);
        chk("t2_hi", 0, 32'(hi), 3);
        chk("t2_lo", 0, 32'(lo), 2);

        // 3: clamp of 0 and 1, then widest ratio
        load(1, 0);
        load(1, 1);
        wait_pend_clear(1);
        run_lens(1, hi, lo);
        chk("t3_clamp_hi", 1, 32'(hi), 1);
        chk("t3_clamp_lo", 1, 32'(lo), 1);
        load(1, 255);
        wait_pend_clear(1);
        run_lens(1, hi, lo);
        chk("t3_max_hi", 1, 32'(hi), 128);
        chk("t3_max_lo", 1, 32'(lo), 127);

        // 4: disable ch0 at cnt 1 with ratio 6
        load(0, 6);
        wait_pend_clear(0);
        wait_tick(0);
        ch_en[0] = 1'b0;
        exp_seq = 8'b0000_0011;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t4_drain_clk", i, 32'(clk_out[0]), 32'(exp_seq[i]));
            chk("t4_drain_tick", i, 32'(tick[0]), 0);
        end
        ch_en[0] = 1'b1;
        cyc();
        chk("t4_reen_clk", 0, 32'(clk_out[0]), 1);
        chk("t4_reen_tick", 0, 32'(tick[0]), 1);

        // 5: last load wins; load on the boundary cycle waits one period
        load(0, 4);
        load(0, 7);
        wait_pend_clear(0);
        run_lens(0, hi, lo);
        chk("t5_last_hi", 0, 32'(hi), 4);
        chk("t5_last_lo", 0, 32'(lo), 3);
        repeat (5) cyc();
        load(0, 3);
        run_lens(0, hi, lo);
        chk("t5_bnd_old_hi", 0, 32'(hi), 4);
        chk("t5_bnd_old_lo", 0, 32'(lo), 3);
        run_lens(0, hi, lo);
        chk("t5_bnd_new_hi", 0, 32'(hi), 2);
        chk("t5_bnd_new_lo", 0, 32'(lo), 1);

        // 6: reset during a high phase with a pending load
        load(1, 9);
        wait_tick(0);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_clk_out", 0, 32'(clk_out), 0);
        chk("t6_async_tick", 0, 32'(tick), 0);
        chk("t6_async_upd_pend", 0, 32'(upd_pend), 0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t6_default_clk", i, 32'(clk_out), (i % 2 == 0) ? 32'd3 : 32'd0);
        end

        // randomized enables and loads against the model
        for (int i = 0; i < 3000; i++) begin
            int c;
            c = int'($urandom_range(0, NUM_CH - 1));
            if ($urandom_range(0, 19) == 0) ch_en[c] = ~ch_en[c];
            if ($urandom_range(0, 14) == 0) begin
                div_val[c*DIV_W +: DIV_W] = ($urandom_range(0, 9) == 0) ?
                    DIV_W'($urandom_range(0, 255)) : DIV_W'($urandom_range(0, 9));
                div_load[c] = 1'b1;
            end
            cyc();
            div_load = '0;
        end

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
